// File: rtl/mesi_bus_arbiter_lv1_pkg.sv
// Shared constants for the MESI L1 snoop-bus arbiter: bus command codes,
// controller states and the default core count.
package mesi_bus_pkg_lv1;

    localparam int DEF_NUM_CORES = 4;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_RDX = 2'b10;
    localparam logic [1:0] CMD_INV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/mesi_bus_arbiter_lv1_if.sv
// Snoop-bus bundle between the L1 controllers (master side) and the bus
// arbiter (slave side).
interface mesi_bus_arbiter_lv1_if
    import mesi_bus_pkg_lv1::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ADDR_WID  = 32,
    parameter int CMD_WID   = 2,
    parameter int SRC_WID   = $clog2(NUM_CORES)
);
    logic [NUM_CORES-1:0]          bus_req;
    logic [NUM_CORES*CMD_WID-1:0]  bus_cmd;
    logic [NUM_CORES*ADDR_WID-1:0] bus_addr;
    logic [NUM_CORES-1:0]          snoop_done;
    logic [NUM_CORES-1:0]          snoop_shared;

    logic [NUM_CORES-1:0]          bus_gnt;
    logic                          bus_rd;
    logic                          bus_rdx;
    logic                          invalidate;
    logic [ADDR_WID-1:0]           snoop_addr;
    logic [SRC_WID-1:0]            snoop_src;
    logic [NUM_CORES-1:0]          bus_done;
    logic                          bus_shared;
    logic                          bus_err;
    logic                          busy;

    modport master (
        output bus_req, bus_cmd, bus_addr, snoop_done, snoop_shared,
        input  bus_gnt, bus_rd, bus_rdx, invalidate, snoop_addr, snoop_src,
               bus_done, bus_shared, bus_err, busy
    );

    modport slave (
        input  bus_req, bus_cmd, bus_addr, snoop_done, snoop_shared,
        output bus_gnt, bus_rd, bus_rdx, invalidate, snoop_addr, snoop_src,
               bus_done, bus_shared, bus_err, busy
    );

endinterface

// File: rtl/mesi_bus_arbiter_lv1_rr_arbiter.sv
// Combinational round-robin pick: first set request bit searching upward
// from last_gnt+1, wrapping modulo NUM_CORES (a power of two).
module rr_arbiter_lv1 #(
    parameter int NUM_CORES = 4,
    parameter int SRC_WID   = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [SRC_WID-1:0]   last_gnt,
    output logic [NUM_CORES-1:0] gnt,
    output logic [SRC_WID-1:0]   idx,
    output logic                 valid
);

    logic [SRC_WID-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        // i == NUM_CORES wraps back to last_gnt itself, so it has lowest priority
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = last_gnt + SRC_WID'(i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mesi_bus_arbiter_lv1.sv
// Snoop-bus controller for the 4-core MESI L1 complex: round-robin grant,
// command broadcast, snoop completion/shared collection with timeout.
//
//   state | meaning
//   IDLE  | waiting for any bus_req; picks winner and latches cmd/addr
//   SNOOP | command broadcast, collecting snoop_done / snoop_shared
//   DONE  | one-cycle bus_done pulse to owner with shared/err result
module mesi_bus_arbiter_lv1
    import mesi_bus_pkg_lv1::*;
#(
    parameter int NUM_CORES   = DEF_NUM_CORES,
    parameter int ADDR_WID    = 32,
    parameter int CMD_WID     = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    mesi_bus_arbiter_lv1_if.slave  bus
);

    localparam int SRC_WID = $clog2(NUM_CORES);
    localparam int CNT_WID = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_SNOOP = 2'(SNOOP);
    localparam logic [1:0] ST_DONE  = 2'(DONE);

    logic [1:0]           state;
    logic [SRC_WID-1:0]   owner;
    logic [SRC_WID-1:0]   last_gnt;
    logic [CMD_WID-1:0]   cmd_q;
    logic [ADDR_WID-1:0]  addr_q;
    logic [NUM_CORES-1:0] mask;
    logic                 shared_acc;
    logic                 err_q;
    logic [CNT_WID-1:0]   tmr;

    logic [NUM_CORES-1:0] win_gnt;
    logic [SRC_WID-1:0]   win_idx;
    logic                 win_valid;
    logic [CMD_WID-1:0]   win_cmd;
    logic [ADDR_WID-1:0]  win_addr;
    logic [NUM_CORES-1:0] owner_oh;
    logic [NUM_CORES-1:0] mask_nxt;
    logic                 shared_nxt;

    rr_arbiter_lv1 #(
        .NUM_CORES (NUM_CORES),
        .SRC_WID   (SRC_WID)
    ) u_rr (
        .req      (bus.bus_req),
        .last_gnt (last_gnt),
        .gnt      (win_gnt),
        .idx      (win_idx),
        .valid    (win_valid)
    );

    always_comb begin
        win_cmd  = '0;
        win_addr = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (win_gnt[i]) begin
                win_cmd  = bus.bus_cmd[i*CMD_WID +: CMD_WID];
                win_addr = bus.bus_addr[i*ADDR_WID +: ADDR_WID];
            end
        end
    end

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    // Owner bit is preset in mask, and its own shared indication is masked off
    assign mask_nxt   = mask | bus.snoop_done;
    assign shared_nxt = shared_acc | (|(bus.snoop_done & bus.snoop_shared & ~owner_oh));

    // Timeout is a down-counter loaded at grant; reaching zero in SNOOP forces completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_gnt   <= SRC_WID'(NUM_CORES - 1);
            cmd_q      <= '0;
            addr_q     <= '0;
            mask       <= '0;
            shared_acc <= 1'b0;
            err_q      <= 1'b0;
            tmr        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        owner      <= win_idx;
                        cmd_q      <= win_cmd;
                        addr_q     <= win_addr;
                        mask       <= win_gnt;
                        shared_acc <= 1'b0;
                        err_q      <= 1'b0;
                        tmr        <= CNT_WID'(TIMEOUT_CYC - 1);
                        state      <= (win_cmd == CMD_WID'(CMD_NOP)) ? ST_DONE : ST_SNOOP;
                    end
                end
                ST_SNOOP: begin
                    mask       <= mask_nxt;
                    shared_acc <= shared_nxt;
                    if (&mask_nxt) begin
                        state <= ST_DONE;
                    end else if (tmr == '0) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_DONE: begin
                    last_gnt <= owner;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.bus_gnt    = (state == ST_SNOOP || state == ST_DONE) ? owner_oh : '0;
    assign bus.bus_rd     = (state == ST_SNOOP) && (cmd_q == CMD_WID'(CMD_RD));
    assign bus.bus_rdx    = (state == ST_SNOOP) && (cmd_q == CMD_WID'(CMD_RDX));
    assign bus.invalidate = (state == ST_SNOOP) && (cmd_q == CMD_WID'(CMD_INV));
    assign bus.snoop_addr = addr_q;
    assign bus.snoop_src  = owner;
    assign bus.bus_done   = (state == ST_DONE) ? owner_oh : '0;
    assign bus.bus_shared = (state == ST_DONE) && shared_acc;
    assign bus.bus_err    = (state == ST_DONE) && err_q;
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_mesi_bus_arbiter_lv1.sv
// Self-checking bench for mesi_bus_arbiter_lv1: directed table, held-request
// round-robin, reset abort and randomized transactions against a txn-level model.
module tb_mesi_bus_arbiter_lv1;
    import mesi_bus_pkg_lv1::*;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int CW = 2;
    localparam int TO = 16;
    localparam logic [7:0] NEVER = 8'hFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc_cnt = 0;
    int   model_last = NC - 1;

    mesi_bus_arbiter_lv1_if #(.NUM_CORES(NC), .ADDR_WID(AW), .CMD_WID(CW)) bif ();

    mesi_bus_arbiter_lv1 #(
        .NUM_CORES(NC), .ADDR_WID(AW), .CMD_WID(CW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int              own;
        logic [1:0]      cmd;
        logic [31:0]     addr;
        logic [3:0][7:0] dly;
        logic [3:0]      sh;
        bit              noise;
        int              nsn;
        bit              esh;
        bit              eerr;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_all();
        return {16'h0, bif.bus_gnt, bif.bus_rd, bif.bus_rdx, bif.invalidate, bif.snoop_addr,
                bif.snoop_src, bif.bus_done, bif.bus_shared, bif.bus_err, bif.busy};
    endfunction

    function automatic logic [3:0][7:0] mk_dly(input int d0, input int d1, input int d2, input int d3);
        logic [3:0][7:0] d;
        d[0] = 8'(d0); d[1] = 8'(d1); d[2] = 8'(d2); d[3] = 8'(d3);
        return d;
    endfunction

    function automatic int model_rr(input logic [NC-1:0] req, input int last);
        for (int k = 1; k <= NC; k++) begin
            if (req[(last + k) % NC]) return (last + k) % NC;
        end
        return -1;
    endfunction

    // Transaction-level outcome: snooper j pulses done in SNOOP cycle dly[j]
    function automatic void model_exp(input int own, input logic [1:0] cmd,
                                      input logic [3:0][7:0] dly, input logic [3:0] sh,
                                      output int nsn, output bit esh, output bit eerr);
        int m;
        m = 0; esh = 1'b0;
        if (cmd == CMD_NOP) begin
            nsn = 0; eerr = 1'b0;
            return;
        end
        for (int j = 0; j < NC; j++) if (j != own && int'(dly[j]) > m) m = int'(dly[j]);
        if (m <= TO - 1) begin nsn = m + 1; eerr = 1'b0; end
        else begin nsn = TO; eerr = 1'b1; end
        for (int j = 0; j < NC; j++) if (j != own && int'(dly[j]) < nsn && sh[j]) esh = 1'b1;
    endfunction

    task automatic set_core(input int c, input logic [1:0] cmd, input logic [31:0] addr);
        bif.bus_req[c] = 1'b1;
        bif.bus_cmd[c*CW +: CW] = cmd;
        bif.bus_addr[c*AW +: AW] = addr;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bif.bus_req = '0; bif.bus_cmd = '0; bif.bus_addr = '0;
        bif.snoop_done = '0; bif.snoop_shared = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs_all(), 64'h0);
        rst_n = 1'b1;
        model_last = NC - 1;
    endtask

    // Entry and exit at a negedge with the DUT in IDLE; requests already driven.
    task automatic do_txn(input string tag, input int own, input logic [3:0][7:0] dly,
                          input logic [3:0] sh, input bit noise, input int exp_nsn,
                          input bit exp_sh, input bit exp_err, input bit drop, output int done_cyc);
        logic [1:0]    exp_cmd;
        logic [31:0]   exp_addr;
        logic [2:0]    exp_str;
        logic [NC-1:0] own_oh;
        int nsn;
        bit got, bad_str, bad_gnt;
        exp_cmd  = bif.bus_cmd[own*CW +: CW];
        exp_addr = bif.bus_addr[own*AW +: AW];
        exp_str  = {exp_cmd == CMD_RD, exp_cmd == CMD_RDX, exp_cmd == CMD_INV};
        own_oh   = '0; own_oh[own] = 1'b1;
        nsn = 0; got = 0; bad_str = 0; bad_gnt = 0; done_cyc = 0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            if (bif.bus_done != '0) begin
                got = 1; done_cyc = cyc_cnt;
            end else begin
                if ({bif.bus_rd, bif.bus_rdx, bif.invalidate} != exp_str) bad_str = 1;
                if (bif.bus_gnt != own_oh || int'(bif.snoop_src) != own ||
                    bif.snoop_addr != exp_addr || !bif.busy) bad_gnt = 1;
                for (int j = 0; j < NC; j++) begin
                    bif.snoop_done[j]   = (j == own) ? noise : (int'(dly[j]) == nsn);
                    bif.snoop_shared[j] = (j == own) ? noise : sh[j];
                end
                nsn++;
            end
        end
        chk({tag, ".done_seen"}, 64'(got), 64'h1);
        chk({tag, ".snoop_cycles"}, 64'(nsn), 64'(exp_nsn));
        chk({tag, ".strobe_bad"}, 64'(bad_str), 64'h0);
        chk({tag, ".gnt_src_addr_bad"}, 64'(bad_gnt), 64'h0);
        chk({tag, ".done_gnt"}, {bif.bus_done, bif.bus_gnt}, {own_oh, own_oh});
        chk({tag, ".done_strobes"}, {bif.bus_rd, bif.bus_rdx, bif.invalidate}, 64'h0);
        chk({tag, ".shared"}, 64'(bif.bus_shared), 64'(exp_sh));
        chk({tag, ".err"}, 64'(bif.bus_err), 64'(exp_err));
        bif.snoop_done = '0; bif.snoop_shared = '0;
        if (drop) bif.bus_req[own] = 1'b0;
        model_last = own;
        @(negedge clk);
        chk({tag, ".idle_after"}, {bif.busy, bif.bus_done}, 64'h0);
    endtask

    initial begin
        int dc, prev_dc, own, nsn;
        bit esh, eerr, nz;
        logic [3:0][7:0] dly;
        logic [3:0] sh;

        tbl[0] = '{own:2, cmd:CMD_RD,  addr:32'h100,  dly:mk_dly(0, 0, 255, 0),   sh:4'b0000, noise:0, nsn:1,  esh:0, eerr:0};
        tbl[1] = '{own:1, cmd:CMD_RD,  addr:32'h2000, dly:mk_dly(2, 255, 2, 0),   sh:4'b1000, noise:0, nsn:3,  esh:1, eerr:0};
        tbl[2] = '{own:0, cmd:CMD_RDX, addr:32'h3000, dly:mk_dly(255, 0, 255, 0), sh:4'b0000, noise:0, nsn:16, esh:0, eerr:1};
        tbl[3] = '{own:1, cmd:CMD_NOP, addr:32'h40,   dly:mk_dly(0, 0, 0, 0),     sh:4'b1111, noise:0, nsn:0,  esh:0, eerr:0};
        tbl[4] = '{own:3, cmd:CMD_INV, addr:32'h50,   dly:mk_dly(1, 1, 1, 255),   sh:4'b0000, noise:1, nsn:2,  esh:0, eerr:0};
        tbl[5] = '{own:2, cmd:CMD_RD,  addr:32'h60,   dly:mk_dly(3, 16, 255, 15), sh:4'b0010, noise:0, nsn:16, esh:0, eerr:1};
        tbl[6] = '{own:0, cmd:CMD_RDX, addr:32'h70,   dly:mk_dly(255, 15, 5, 15), sh:4'b0100, noise:0, nsn:16, esh:1, eerr:0};

        apply_reset();

        for (int i = 0; i < 7; i++) begin
            set_core(tbl[i].own, tbl[i].cmd, tbl[i].addr);
            do_txn($sformatf("tbl%0d", i), tbl[i].own, tbl[i].dly, tbl[i].sh, tbl[i].noise,
                   tbl[i].nsn, tbl[i].esh, tbl[i].eerr, 1'b1, dc);
        end

        // All four cores request together and keep requesting
        apply_reset();
        for (int c = 0; c < NC; c++) set_core(c, CMD_RD, 32'h1000 + 32'(c));
        prev_dc = 0;
        for (int t = 0; t < 2 * NC; t++) begin
            do_txn($sformatf("held%0d", t), t % NC, mk_dly(0, 0, 0, 0), 4'b0000, 1'b0,
                   1, 1'b0, 1'b0, 1'b0, dc);
            if (t > 0) chk($sformatf("held%0d.spacing", t), 64'(dc - prev_dc), 64'd3);
            prev_dc = dc;
        end
        bif.bus_req = '0;
        @(negedge clk);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NC; c++) begin
                if (!bif.bus_req[c] && $urandom_range(1, 0) == 1)
                    set_core(c, 2'($urandom_range(3, 0)), $urandom());
            end
            if (bif.bus_req == '0) set_core(int'($urandom_range(NC - 1, 0)), CMD_RD, $urandom());
            own = model_rr(bif.bus_req, model_last);
            for (int j = 0; j < NC; j++) begin
                dly[j] = ($urandom_range(9, 0) == 0) ? NEVER : 8'($urandom_range(17, 0));
                sh[j]  = 1'($urandom_range(1, 0));
            end
            nz = 1'($urandom_range(1, 0));
            model_exp(own, bif.bus_cmd[own*CW +: CW], dly, sh, nsn, esh, eerr);
            do_txn($sformatf("rnd%0d", t), own, dly, sh, nz, nsn, esh, eerr, 1'b1, dc);
        end

        // Reset asserted during an Invalidate's second SNOOP cycle
        apply_reset();
        set_core(3, CMD_INV, 32'hDEAD0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_abort.pre_inv", {bif.invalidate, bif.bus_gnt}, {1'b1, 4'b1000});
        rst_n = 1'b0;
        #1;
        chk("rst_abort.outputs_zero", outs_all(), 64'h0);
        nz = 0;
        repeat (3) begin
            @(negedge clk);
            if (bif.bus_done != '0 || bif.busy) nz = 1;
        end
        chk("rst_abort.no_done", 64'(nz), 64'h0);
        set_core(0, CMD_RD, 32'hA0);
        rst_n = 1'b1;
        model_last = NC - 1;
        do_txn("rst_abort.core0_first", 0, mk_dly(255, 0, 0, 0), 4'b0000, 1'b0,
               1, 1'b0, 1'b0, 1'b1, dc);
        bif.bus_req = '0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mesi_bus_arbiter_lv1.md
Name: mesi_bus_arbiter_lv1

Overview:
- Shared snoop-bus controller for the 4-core MESI L1 complex.
- Arbitrates bus requests from the per-core L1 controllers round-robin.
- Broadcasts the winner's command (BusRd, BusRdX, Invalidate) and address to all snoopers, then collects snoop completion and shared indications.
- Returns done/shared to the owner, which uses shared to choose the E or S fill state. Sits between the four L1 cache controllers and the snoop-side MESI update logic.

Parameters:
NUM_CORES, 4, number of requesters/snoopers (power of 2, >=2)
ADDR_WID, 32, snoop address width
CMD_WID, 2, command width per core
TIMEOUT_CYC, 16, max SNOOP-state cycles before forced completion (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
bus_req  input  NUM_CORES  per-core level request; held until that core's bus_done
bus_cmd  input  NUM_CORES*CMD_WID  packed per-core command, core i at [i*CMD_WID +: CMD_WID]
bus_addr  input  NUM_CORES*ADDR_WID  packed per-core address
snoop_done  input  NUM_CORES  per-core snoop finished (level or pulse)
snoop_shared  input  NUM_CORES  snooper holds a valid copy; sampled with snoop_done
bus_gnt  output  NUM_CORES  one-hot grant, high in SNOOP and DONE
bus_rd  output  1  broadcast BusRd, high in SNOOP
bus_rdx  output  1  broadcast BusRdX, high in SNOOP
invalidate  output  1  broadcast Invalidate, high in SNOOP
snoop_addr  output  ADDR_WID  latched owner address
snoop_src  output  $clog2(NUM_CORES)  owner core id
bus_done  output  NUM_CORES  one-cycle one-hot completion pulse to owner
bus_shared  output  1  OR of collected shared bits; valid while bus_done is high
bus_err  output  1  timeout flag; valid while bus_done is high
busy  output  1  state != IDLE

Behaviour:
- Command encoding: 00 NOP, 01 BUS_RD, 10 BUS_RDX, 11 INVALIDATE.
- At most one of bus_rd, bus_rdx and invalidate is high at a time.
- Reset, asynchronous:
  - state = IDLE; all outputs 0.
  - Round-robin pointer last_gnt = NUM_CORES-1, so core 0 has first priority.
  - Collect mask, shared accumulator and timeout counter cleared.
  - Reset mid-transaction aborts it silently; no bus_done is issued.
- Outputs are Moore-style, decoded from registered state and latched registers.
- IDLE:
  - If any bus_req is set, the winner is the first set bit searching from last_gnt+1 modulo NUM_CORES.
  - Latch winner id, its cmd and its addr.
  - Clear the collect mask and set the owner bit in it; clear the shared accumulator and counter.
  - Next state: SNOOP, or DONE directly if cmd is NOP.
- SNOOP:
  - bus_gnt[owner] and the command strobe decoded from the latched cmd are asserted.
  - Each cycle, OR snoop_done into the collect mask.
  - For non-owner cores with snoop_done=1, OR snoop_shared into the accumulator.
  - The owner's snoop_done and snoop_shared are ignored.
  - When the mask including this cycle's inputs is all ones, go to DONE with err=0.
  - Otherwise, if counter == TIMEOUT_CYC-1, go to DONE with err=1.
  - Otherwise increment the counter.
  - A snooper's done counts once; repeat pulses are harmless.
- DONE, one cycle:
  - bus_gnt[owner], bus_done[owner], bus_shared and bus_err are driven.
  - last_gnt = owner; next state IDLE.
- Latency: request seen in IDLE at cycle 0; SNOOP at cycle 1; earliest bus_done at cycle 2 (all snoopers done in cycle 1). NOP gives bus_done at cycle 1.
- Requester handshake:
  - The requester drops bus_req on the edge where it samples bus_done, so the following IDLE cycle sees the updated request.
  - A request still high in IDLE is a new transaction.
- Owner drops bus_req mid-transaction: protocol violation; ignored, the transaction completes normally.
- Non-owner requests arriving during SNOOP/DONE wait. No starvation: each core is granted within NUM_CORES transactions.
- One transaction in flight; no pipelining.

Decomposition:
- Package mesi_bus_pkg_lv1 holds:
  - command localparams CMD_NOP/CMD_RD/CMD_RDX/CMD_INV;
  - state enum IDLE/SNOOP/DONE;
  - default NUM_CORES.
- Sub-module rr_arbiter_lv1 is a combinational round-robin pick: req vector plus last_gnt in, one-hot plus index out. The FSM and collect logic stay in the top.

Test Plan:
- After reset, core 2 requests BUS_RD at addr 0x100; cores 0, 1 and 3 assert snoop_done next cycle with shared=0 -> bus_rd high 1 cycle, snoop_addr=0x100, snoop_src=2, bus_done=4'b0100 at cycle 2, bus_shared=0, bus_err=0.
- Cores 0–3 all request simultaneously from reset, snoopers respond immediately -> grant order 0,1,2,3, each bus_done 3 cycles apart; repeat with all held -> order continues 0,1,2,3.
- Core 1 BUS_RD; core 3 returns snoop_done+shared=1 in cycle 1; cores 0 and 2 return done in cycle 3 with shared=0 -> bus_done[1] at cycle 4 with bus_shared=1.
- Core 0 BUS_RDX; core 2 never asserts snoop_done -> bus_done[0] after 16 SNOOP cycles, bus_err=1, bus_rdx high for exactly 16 cycles.
- Core 3 INVALIDATE with rst_n pulled low in SNOOP cycle 2 -> all outputs 0 immediately, no bus_done; after release, core 0 request is granted first.
- Core 1 NOP -> no strobe asserted, bus_done[1] at cycle 1, bus_shared=0.
